// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional DMEM_BYTE_EN build adds lb/sb lane handling.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // LATENCY is limited to 1..15, so four bits cover the countdown
    localparam int CNT_W = 4;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        unique case (lane)
            LANE_0: be = 4'b0001;
            LANE_1: be = 4'b0010;
            LANE_2: be = 4'b0100;
            LANE_3: be = 4'b1000;
        endcase
        return be;
    endfunction

    function automatic logic [7:0] lane_byte(
        input logic [31:0] word,
        input logic [1:0]  lane
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (lane)
            LANE_0: b = word[7:0];
            LANE_1: b = word[15:8];
            LANE_2: b = word[23:16];
            LANE_3: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory.
// ReqByte is only honoured in DMEM_BYTE_EN builds.
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        ReqByte;
    logic        RespValid;
    logic [31:0] RespData;
    logic        AddrError;
    logic        Stall;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByte,
        input  ReqReady, RespValid, RespData, AddrError, Stall
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByte,
        output ReqReady, RespValid, RespData, AddrError, Stall
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Contents are never reset; a write returns zero on the read port.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge Clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
                r_rdata <= '0;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Define DMEM_BYTE_EN to enable lb/sb byte-lane accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    data_mem_responder_if.slave  bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam bit LAT1 = (LATENCY == 1);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_write;
    logic            r_byte;
    logic            r_err;
    logic [1:0]      r_lane;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;

    logic            w_accept;
    logic            w_byte;
    logic            w_misalign;
    logic            w_wait_done;
    logic            w_go;
    logic            w_a_write;
    logic            w_a_byte;
    logic            w_a_err;
    logic [1:0]      w_a_lane;
    logic [AW-1:0]   w_a_idx;
    logic [31:0]     w_a_wdata;
    logic            w_en;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_rdata;
    logic            w_unused;

`ifdef DMEM_BYTE_EN
    assign w_byte   = bus.ReqByte;
    assign w_unused = ^{1'b0, bus.ReqAddr[31:AW+2]};
`else
    assign w_byte   = 1'b0;
    assign w_unused = ^{bus.ReqByte, bus.ReqAddr[31:AW+2]};
`endif

    assign w_accept    = bus.ReqValid && (r_state == ST_IDLE);
    assign w_misalign  = !w_byte && (bus.ReqAddr[1:0] != 2'b00);
    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

    // With LATENCY==1 the array is hit on the accept edge itself,
    // so the request fields come straight off the bus.
    always_comb begin
        w_a_write = r_write;
        w_a_byte  = r_byte;
        w_a_err   = r_err;
        w_a_lane  = r_lane;
        w_a_idx   = r_idx;
        w_a_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_a_write = bus.ReqWrite;
            w_a_byte  = w_byte;
            w_a_err   = w_misalign;
            w_a_lane  = bus.ReqAddr[1:0];
            w_a_idx   = bus.ReqAddr[AW+1:2];
            w_a_wdata = bus.ReqWData;
        end
    end

    // Gating with Rst keeps a reset on the RESP-entry edge from writing
    assign w_go = Rst && ((w_accept && LAT1) || w_wait_done);
    assign w_en = w_go && !w_a_err;

    always_comb begin
        w_be    = 4'hf;
        w_wdata = w_a_wdata;
        if (w_a_byte) begin
            w_be    = lane_be(w_a_lane);
            w_wdata = {4{w_a_wdata[7:0]}};
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .Clk     (Clk),
        .i_en    (w_en),
        .i_we    (w_a_write),
        .i_be    (w_be),
        .i_addr  (w_a_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_err   <= 1'b0;
            r_lane  <= 2'b00;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.ReqWrite;
                        r_byte  <= w_byte;
                        r_err   <= w_misalign;
                        r_lane  <= bus.ReqAddr[1:0];
                        r_idx   <= bus.ReqAddr[AW+1:2];
                        r_wdata <= bus.ReqWData;
                        if (LAT1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.RespData = 32'h0;
        if ((r_state == ST_RESP) && !r_write && !r_err) begin
            bus.RespData = r_byte ? {24'h0, lane_byte(w_rdata, r_lane)}
                                  : w_rdata;
        end
    end

    assign bus.ReqReady  = (r_state == ST_IDLE);
    assign bus.RespValid = (r_state == ST_RESP);
    assign bus.AddrError = (r_state == ST_RESP) && r_err;
    assign bus.Stall     = w_accept || (r_state == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a timestamp-based model.
// Byte-lane vectors are selected by DMEM_BYTE_EN.
module tb_data_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    always #5 Clk = ~Clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a request accepted at edge A owns the responder until
    // edge A+LATENCY; its response is visible in cycle A+LATENCY-1.
    int          cyc = 0;
    bit          live = 0;
    bit          pend = 0;
    int          due = 0;
    bit          m_write, m_byte, m_err;
    logic [1:0]  m_lane;
    int          m_idx;
    logic [31:0] m_wdata, m_rdata, m_word;
    logic [31:0] mmem [int];
    int          resp_seen = 0;

    always @(posedge Clk) begin
        cyc++;
        live = 1;
        if (!Rst) begin
            pend = 0;
        end else begin
            if (pend && cyc == due + 1) begin
                pend = 0;
            end else if (!pend && bus.ReqValid) begin
                pend    = 1;
                due     = cyc + LATENCY - 1;
                m_write = bus.ReqWrite;
`ifdef DMEM_BYTE_EN
                m_byte  = bus.ReqByte;
`else
                m_byte  = 0;
`endif
                m_lane  = bus.ReqAddr[1:0];
                m_err   = !m_byte && (bus.ReqAddr[1:0] != 2'b00);
                m_idx   = int'((bus.ReqAddr >> 2) % DEPTH);
                m_wdata = bus.ReqWData;
                m_rdata = 32'h0;
            end
            if (pend && cyc == due && !m_err) begin
                m_word = mmem.exists(m_idx) ? mmem[m_idx] : 32'h0;
                if (m_write) begin
                    if (m_byte) m_word[8*m_lane +: 8] = m_wdata[7:0];
                    else        m_word = m_wdata;
                    mmem[m_idx] = m_word;
                end else if (m_byte) begin
                    m_rdata = (m_word >> (8 * m_lane)) & 32'hff;
                end else begin
                    m_rdata = m_word;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (live) begin
            logic rv;
            rv = pend && (cyc == due);
            check("ReqReady",  {31'b0, bus.ReqReady},  {31'b0, !pend});
            check("Stall",     {31'b0, bus.Stall},
                  {31'b0, (!pend && bus.ReqValid) || (pend && cyc < due)});
            check("RespValid", {31'b0, bus.RespValid}, {31'b0, rv});
            check("RespData",  bus.RespData, rv ? m_rdata : 32'h0);
            check("AddrError", {31'b0, bus.AddrError},
                  {31'b0, rv && m_err});
            if (bus.RespValid) resp_seen++;
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit byt,
                        input bit hold, output logic [31:0] rdata,
                        output logic err, output int lat,
                        output int stalls);
        bit got;
        bus.ReqValid = 1'b1;
        bus.ReqWrite = wr;
        bus.ReqAddr  = addr;
        bus.ReqWData = wdata;
        bus.ReqByte  = byt;
        stalls = 0;
        lat    = 0;
        rdata  = 32'hffff_ffff;
        err    = 1'b1;
        got    = 0;
        @(negedge Clk);
        if (bus.Stall) stalls++;
        @(posedge Clk);
        #1;
        if (!hold) bus.ReqValid = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge Clk);
            if (bus.Stall) stalls++;
            if (bus.RespValid) begin
                got   = 1;
                lat   = n;
                rdata = bus.RespData;
                err   = bus.AddrError;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout: got no RespValid, expected one for addr %h",
                     addr);
        end
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqByte  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, st, base;

        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 32'h0;
        bus.ReqWData = 32'h0;
        bus.ReqByte  = 1'b0;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_ready", {31'b0, bus.ReqReady},  32'd1);
        check("rst_rv",    {31'b0, bus.RespValid}, 32'd0);
        check("rst_data",  bus.RespData,           32'd0);
        check("rst_err",   {31'b0, bus.AddrError}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0, rd, er, lat, st);
        check("sw_latency", lat, 32'd2);
        check("sw_stalls",  st,  32'd2);
        check("sw_data",    rd,  32'h0);
        check("sw_err",     {31'b0, er}, 32'd0);

        xfer(0, 32'h10, 32'h0, 0, 0, rd, er, lat, st);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_err",  {31'b0, er}, 32'd0);

        xfer(0, 32'h13, 32'h0, 0, 0, rd, er, lat, st);
        check("mis_ld_data", rd, 32'h0);
        check("mis_ld_err",  {31'b0, er}, 32'd1);
        xfer(1, 32'h12, 32'h12345678, 0, 0, rd, er, lat, st);
        check("mis_st_err",  {31'b0, er}, 32'd1);
        xfer(0, 32'h10, 32'h0, 0, 0, rd, er, lat, st);
        check("mis_unchanged", rd, 32'hDEADBEEF);

        xfer(1, 32'h14, 32'hCAFEF00D, 0, 0, rd, er, lat, st);
        xfer(0, 32'h14, 32'h0, 0, 0, rd, er, lat, st);
        check("lw_14", rd, 32'hCAFEF00D);

`ifdef DMEM_BYTE_EN
        xfer(1, 32'h11, 32'h000000AB, 1, 0, rd, er, lat, st);
        check("sb_err", {31'b0, er}, 32'd0);
        xfer(0, 32'h10, 32'h0, 0, 0, rd, er, lat, st);
        check("sb_word", rd, 32'hDEADABEF);
        xfer(0, 32'h11, 32'h0, 1, 0, rd, er, lat, st);
        check("lb_11", rd, 32'h000000AB);
        xfer(0, 32'h13, 32'h0, 1, 0, rd, er, lat, st);
        check("lb_13", rd, 32'h000000DE);
`else
        xfer(1, 32'h11, 32'h000000AB, 1, 0, rd, er, lat, st);
        check("byte_ignored_err", {31'b0, er}, 32'd1);
        xfer(0, 32'h10, 32'h0, 0, 0, rd, er, lat, st);
        check("byte_ignored_word", rd, 32'hDEADBEEF);
`endif

        xfer(1, 32'h20, 32'h11112222, 0, 0, rd, er, lat, st);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = 32'h20;
        bus.ReqWData = 32'h55555555;
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_mid_ready", {31'b0, bus.ReqReady},  32'd1);
        check("rst_mid_rv",    {31'b0, bus.RespValid}, 32'd0);
        @(posedge Clk);
        #1;
        xfer(0, 32'h20, 32'h0, 0, 0, rd, er, lat, st);
        check("rst_no_write", rd, 32'h11112222);

        base = resp_seen;
        xfer(1, 32'(4 * DEPTH + 8), 32'h0BADF00D, 0, 1, rd, er, lat, st);
        repeat (4) @(negedge Clk);
        #1;
        check("hold_one_resp", resp_seen - base, 32'd1);
        @(posedge Clk);
        #1;
        xfer(0, 32'h8, 32'h0, 0, 0, rd, er, lat, st);
        check("alias_word2", rd, 32'h0BADF00D);

        repeat (2) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words in the data memory.
REQ-002 The module SHALL have parameter LATENCY, default 2, giving the cycles from request accept to response (legal range 1..15).
REQ-003 Port Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port Rst  in  1  reset, synchronous, active-low.
REQ-005 Port ReqValid  in  1  MEM stage presents a request.
REQ-006 Port ReqReady  out  1  responder accepts a request this cycle.
REQ-007 Port ReqWrite  in  1  1 = store, 0 = load.
REQ-008 Port ReqAddr  in  32  byte address.
REQ-009 Port ReqWData  in  32  store data.
REQ-010 Port ReqByte  in  1  byte access (lb/sb), honoured only under DMEM_BYTE_EN.
REQ-011 Port RespValid  out  1  one-cycle response strobe.
REQ-012 Port RespData  out  32  load data, valid with RespValid.
REQ-013 Port AddrError  out  1  misaligned request flag, valid with RespValid.
REQ-014 Port Stall  out  1  freeze request to the hazard unit (PCWrite/IF_ID_Write low).

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 ReqReady SHALL be 1 only in IDLE, and a request SHALL be accepted when ReqValid && ReqReady.
REQ-017 On accept, address, data, write and byte fields SHALL be captured, and the FSM SHALL go to WAIT if LATENCY>1, else to RESP.
REQ-018 WAIT SHALL count down LATENCY-1 cycles, then go to RESP.
REQ-019 The array access SHALL occur on entry to RESP, and RespValid SHALL be 1 for exactly the RESP cycle, which is LATENCY cycles after the accept edge; RESP then goes to IDLE.
REQ-020 Load: RespData = mem[index]; store: mem[index] updated, RespData = 0.
REQ-021 Index SHALL be ReqAddr[clog2(DEPTH)+1:2]; out-of-range addresses wrap modulo DEPTH.
REQ-022 A word request with ReqAddr[1:0] != 0 SHALL skip the array, return RespData=0 and assert AddrError with RespValid.
REQ-023 Stall = (ReqValid && state==IDLE) || state==WAIT; Stall SHALL be 0 in the RESP cycle so the pipeline advances with the data.
REQ-024 ReqValid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 A load following a store to the same address SHALL return the stored value.
REQ-026 RespData and AddrError SHALL be 0 whenever RespValid is 0.

Reset
REQ-027 With Rst low at a clock edge, the FSM SHALL be in IDLE, the counter 0, RespValid=0, RespData=0, AddrError=0 and ReqReady=1.
REQ-028 Reset mid-transaction SHALL discard the pending request, a store not yet in RESP SHALL NOT write, and the array contents SHALL NOT be cleared.

Configuration
REQ-029 With DMEM_BYTE_EN defined, ReqByte=1 SHALL select lane ReqAddr[1:0] (lane 0 = bits 7:0): sb writes only that byte; lb returns it zero-extended in RespData; no alignment error.
REQ-030 Without DMEM_BYTE_EN, ReqByte SHALL be ignored, all accesses SHALL be word accesses, and REQ-022 applies.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state encoding, counter width constant and lane-select constants.
REQ-032 The storage SHALL be sub-module dmem_array: single-port synchronous RAM with 4 byte-write enables (tied all-on without DMEM_BYTE_EN).

Verification
REQ-033 Reset, then store 0xDEADBEEF to 0x10, LATENCY=2 -> RespValid 2 cycles after accept, Stall high 2 cycles, RespData=0.
REQ-034 Load 0x10 after REQ-033 -> RespData=0xDEADBEEF, AddrError=0.
REQ-035 Word load at 0x13 -> RespValid with AddrError=1 and RespData=0; memory unchanged.
REQ-036 DMEM_BYTE_EN: sb 0xAB to 0x11, then word load 0x10 -> 0xDEADABEF; lb 0x11 -> 0x000000AB.
REQ-037 Store to 0x20 with Rst pulsed low in WAIT -> IDLE next cycle, load 0x20 returns prior value.
REQ-038 ReqValid held high during WAIT and address 4*DEPTH+8 -> one accept only; the access aliases to word 2.
